// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter, its four upstream FIFOs
// and the single downstream FIFO.
interface fifo_rr_arbiter_if #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned NUM_Q     = 4
);
    logic [NUM_Q-1:0]           fifo_empty;
    logic [NUM_Q*DATA_SIZE-1:0] data_in;
    logic                       out_almost_full;
    logic                       out_fifo_full;
    logic [NUM_Q-1:0]           pop;
    logic                       push;
    logic [DATA_SIZE-1:0]       data_out;
    logic [1:0]                 grant;
    logic [1:0]                 state;
    logic [7:0]                 push_count;

    // Arbiter side
    modport master (
        input  fifo_empty, data_in, out_almost_full, out_fifo_full,
        output pop, push, data_out, grant, state, push_count
    );

    // FIFO / environment side
    modport slave (
        output fifo_empty, data_in, out_almost_full, out_fifo_full,
        input  pop, push, data_out, grant, state, push_count
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter draining four upstream FIFOs into one downstream FIFO.
// Pop is combinational from registered state; push/data_out follow one cycle later.
module fifo_rr_arbiter #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned NUM_Q     = 4
) (
    input  logic               clk,
    input  logic               reset_L,
    fifo_rr_arbiter_if.master  bus
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StStall  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] grant_q;
    logic [1:0] pick;
    logic       found;
    logic       stall;
    logic       any_ready;
    logic       push_q;
    logic [7:0] count_q;

    always_comb begin
        stall     = bus.out_almost_full | bus.out_fifo_full;
        any_ready = ~&bus.fifo_empty;
        if (stall) begin
            state_d = StStall;
        end else if (any_ready) begin
            state_d = StActive;
        end else begin
            state_d = StIdle;
        end
    end

    // Search starts just past the last grant, so a FIFO repeats only when it is alone.
    always_comb begin
        pick  = grant_q;
        found = 1'b0;
        for (int k = 1; k <= int'(NUM_Q); k++) begin
            if (!found && !bus.fifo_empty[grant_q + 2'(k)]) begin
                found = 1'b1;
                pick  = grant_q + 2'(k);
            end
        end
    end

    always_comb begin
        bus.pop = '0;
        if (reset_L && state_d == StActive && found) begin
            bus.pop[pick] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StIdle;
            grant_q <= 2'd3;
            push_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            push_q  <= |bus.pop;
            if (|bus.pop) begin
                grant_q <= pick;
            end
            if (push_q) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    // grant_q already names the FIFO whose read data arrives this cycle.
    always_comb begin
        bus.data_out = '0;
        if (push_q) begin
            bus.data_out = bus.data_in[int'(grant_q)*int'(DATA_SIZE) +: DATA_SIZE];
        end
    end

    assign bus.push       = push_q;
    assign bus.grant      = grant_q;
    assign bus.state      = state_q;
    assign bus.push_count = count_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomized bench for fifo_rr_arbiter: upstream FIFOs are modelled as arrays,
// expectations come from a transaction-level round-robin model.
module tb_fifo_rr_arbiter;

    localparam int DW    = 6;
    localparam int NQ    = 4;
    localparam int DEPTH = 1024;

    logic clk;
    logic reset_L;

    fifo_rr_arbiter_if #(.DATA_SIZE(DW), .NUM_Q(NQ)) bus ();

    fifo_rr_arbiter #(.DATA_SIZE(DW), .NUM_Q(NQ)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO contents
    logic [DW-1:0] mem [NQ][DEPTH];
    int            head [NQ];
    int            tail [NQ];

    // Reference model
    int            m_grant;
    int            m_state;
    int            m_count;
    bit            m_push;
    logic [DW-1:0] m_data;

    int            af_pct, ff_pct, refill_pct;
    logic          af, ff;
    logic [NQ*DW-1:0] din;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int level(input int i);
        return tail[i] - head[i];
    endfunction

    function automatic int total();
        int t = 0;
        for (int i = 0; i < NQ; i++) t += level(i);
        return t;
    endfunction

    function automatic int pick_rr();
        if (af || ff) return -1;
        for (int k = 1; k <= NQ; k++) begin
            int i = (m_grant + k) % NQ;
            if (level(i) > 0) return i;
        end
        return -1;
    endfunction

    task automatic put(input int i, input logic [DW-1:0] w);
        mem[i][tail[i] % DEPTH] = w;
        tail[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NQ; i++) bus.fifo_empty[i] = (level(i) == 0);
        bus.data_in         = din;
        bus.out_almost_full = af;
        bus.out_fifo_full   = ff;
    endtask

    // One clock: check outputs at negedge, advance model and environment after posedge.
    task automatic step();
        int         sel;
        int         nxt;
        logic [3:0] ep;
        @(negedge clk);
        sel = pick_rr();
        ep  = (sel >= 0) ? 4'(1 << sel) : 4'b0;
        check("pop",        32'(bus.pop),        32'(ep));
        check("push",       32'(bus.push),       32'(m_push));
        check("data_out",   32'(bus.data_out),   m_push ? 32'(m_data) : 32'd0);
        check("grant",      32'(bus.grant),      32'(m_grant));
        check("state",      32'(bus.state),      32'(m_state));
        check("push_count", 32'(bus.push_count), 32'(m_count));
        if (af || ff)        nxt = 2;
        else if (total() > 0) nxt = 1;
        else                 nxt = 0;
        @(posedge clk);
        #1;
        if (m_push) m_count = (m_count + 1) % 256;
        m_state = nxt;
        m_push  = (sel >= 0);
        din     = (NQ*DW)'($urandom);
        if (sel >= 0) begin
            m_data = mem[sel][head[sel] % DEPTH];
            head[sel]++;
            m_grant = sel;
            din[sel*DW +: DW] = m_data;
        end
        if (int'($urandom_range(99)) < refill_pct)
            put(int'($urandom_range(NQ-1)), DW'($urandom));
        af = (int'($urandom_range(99)) < af_pct);
        ff = (int'($urandom_range(99)) < ff_pct);
        drive();
    endtask

    task automatic drain();
        int c;
        af_pct = 0; ff_pct = 0; refill_pct = 0;
        for (c = 0; c < 600 && total() > 0; c++) step();
        if (total() > 0) check("drain_timeout", 32'(total()), 32'd0);
        repeat (3) step();
    endtask

    // Called just after a posedge; asserts reset away from any edge.
    task automatic do_reset();
        #2;
        reset_L = 1'b0;
        #1;
        check("rst_pop",        32'(bus.pop),        32'd0);
        check("rst_push",       32'(bus.push),       32'd0);
        check("rst_data_out",   32'(bus.data_out),   32'd0);
        check("rst_grant",      32'(bus.grant),      32'd3);
        check("rst_state",      32'(bus.state),      32'd0);
        check("rst_push_count", 32'(bus.push_count), 32'd0);
        for (int i = 0; i < NQ; i++) head[i] = tail[i];
        af = 1'b0; ff = 1'b0;
        drive();
        m_grant = 3; m_state = 0; m_count = 0; m_push = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_push", 32'(bus.push), 32'd0);
        reset_L = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        af_pct = 0; ff_pct = 0; refill_pct = 0;
        af = 1'b0; ff = 1'b0;
        din = '0;
        for (int i = 0; i < NQ; i++) begin head[i] = 0; tail[i] = 0; end
        m_grant = 3; m_state = 0; m_count = 0; m_push = 1'b0; m_data = '0;
        reset_L = 1'b0;
        drive();

        // Initial reset state
        #12;
        check("init_grant",      32'(bus.grant),      32'd3);
        check("init_state",      32'(bus.state),      32'd0);
        check("init_pop",        32'(bus.pop),        32'd0);
        check("init_push",       32'(bus.push),       32'd0);
        check("init_push_count", 32'(bus.push_count), 32'd0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        // All four loaded: 0,1,2,3,0,...
        for (int i = 0; i < NQ; i++) repeat (3) put(i, DW'($urandom));
        drive();
        drain();

        // Almost-full mid-stream
        for (int i = 0; i < NQ; i++) repeat (4) put(i, DW'($urandom));
        drive();
        repeat (3) step();
        af_pct = 100;
        repeat (3) step();
        af_pct = 0;
        drain();

        // Reset while popping
        for (int i = 0; i < NQ; i++) repeat (4) put(i, DW'($urandom));
        drive();
        repeat (2) step();
        @(negedge clk);
        check("pre_reset_pop_active", 32'(|bus.pop), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) head[i] = tail[i];
        drive();
        do_reset();

        // Single source FIFO 2 holding 0x05, 0x06
        put(2, 6'h05);
        put(2, 6'h06);
        drive();
        drain();
        check("single_push_count", 32'(bus.push_count), 32'd2);
        check("idle_state",        32'(bus.state),      32'd0);
        check("idle_grant",        32'(bus.grant),      32'd2);
        check("idle_pop",          32'(bus.pop),        32'd0);

        // 260 pushes wrap the counter to 4
        do_reset();
        for (int n = 0; n < 260; n++) put(n % NQ, DW'($urandom));
        drive();
        drain();
        check("wrap_push_count", 32'(bus.push_count), 32'd4);

        // Random traffic with stalls
        af_pct = 15; ff_pct = 5; refill_pct = 60;
        repeat (1500) step();
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 6, the width of one data word.
REQ-002 SHALL have parameter NUM_Q, default 4, the number of upstream FIFOs, fixed at 4 in this revision.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port fifo_empty, input, NUM_Q bits: bit i is upstream FIFO i's empty flag, registered on clk in the upstream FIFO.
REQ-006 SHALL have port data_in, input, NUM_Q*DATA_SIZE bits: slice i ([i*DATA_SIZE +: DATA_SIZE]) is FIFO i's read data, valid the cycle after its read strobe.
REQ-007 SHALL have port out_almost_full, input, 1 bit: almost-full flag of the downstream FIFO.
REQ-008 SHALL have port out_fifo_full, input, 1 bit: full flag of the downstream FIFO.
REQ-009 SHALL have port pop, output, NUM_Q bits: one-hot read strobes to the upstream FIFOs.
REQ-010 SHALL have port push, output, 1 bit: write strobe to the downstream FIFO.
REQ-011 SHALL have port data_out, output, DATA_SIZE bits: write data to the downstream FIFO.
REQ-012 SHALL have port grant, output, 2 bits: index of the last FIFO popped.
REQ-013 SHALL have port state, output, 2 bits: current FSM state, encoded IDLE=0, ACTIVE=1, STALL=2.
REQ-014 SHALL have port push_count, output, 8 bits: count of words pushed since reset.

Function
REQ-015 SHALL implement an FSM with states IDLE, ACTIVE and STALL.
REQ-016 SHALL move to IDLE when all fifo_empty bits are 1 and downstream is not stalled.
REQ-017 SHALL move to ACTIVE when any fifo_empty bit is 0, out_almost_full=0 and out_fifo_full=0.
REQ-018 SHALL move to STALL from any state when out_almost_full=1 or out_fifo_full=1; stall has priority over IDLE/ACTIVE.
REQ-019 SHALL, in any cycle, assert at most one pop bit, and only when the computed next state is ACTIVE (pop is combinational from registered state plus current inputs).
REQ-020 SHALL select the pop target round-robin: search starts at (grant+1) mod 4 and takes the first i with fifo_empty[i]=0.
REQ-021 SHALL pop the same FIFO on consecutive cycles only if it is the sole non-empty FIFO.
REQ-022 SHALL update grant to the popped index on the edge that ends the pop cycle; grant holds when no pop occurs.
REQ-023 SHALL assert push exactly one cycle after each pop cycle (push = registered OR of pop), regardless of the state in that later cycle.
REQ-024 SHALL drive data_out as slice grant of data_in while push=1, and as 0 otherwise.
REQ-025 SHALL increment push_count by 1 on each edge where push=1, wrapping from 255 to 0.
REQ-026 SHALL never pop a FIFO whose fifo_empty bit is 1 in that cycle.
REQ-027 SHALL complete the push of an in-flight word when stall asserts in the cycle after its pop; no word is lost or duplicated.

Reset
REQ-028 SHALL, while reset_L=0, asynchronously force state=IDLE, grant=3 (so FIFO 0 is searched first), pop=0, push=0, data_out=0 and push_count=0.
REQ-029 SHALL discard a word popped in the cycle reset asserts; no push follows deassertion.
REQ-030 SHALL allow a first pop no earlier than the first rising edge after reset_L rises.

Verification
REQ-031 Single source: FIFO 2 holds 0x05, 0x06, the others are empty -> pop=0100 for two cycles, push one cycle later each time, data_out 0x05 then 0x06, push_count=2.
REQ-032 All four FIFOs non-empty after reset -> pop sequence 0001, 0010, 0100, 1000, 0001; grant follows 0, 1, 2, 3, 0.
REQ-033 out_almost_full rises mid-stream -> state=STALL next edge, pop=0 that cycle, the pending push still completes, popping resumes from (grant+1) after the flag drops.
REQ-034 reset_L pulled low with pop active -> all outputs 0 immediately, grant=3, no push after release.
REQ-035 260 words pushed -> push_count wraps to 4.
REQ-036 All FIFOs empty after traffic -> state=IDLE, pop=0, push=0, grant holds its last value.
